adc_decimator: RTL and testbench
================================

ADC_DECIMATOR -- requirements
Module: adc_decimator

Interface
REQ-001 SHALL have parameter MAX_LOG2_RATIO, default 8, meaning the largest supported log2 decimation ratio.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24, meaning the signed sample width taken from input bits [31:8].
REQ-003 SHALL have port aclk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  decimation run; low holds the block idle.
REQ-006 SHALL have port log2_ratio  input  4  requested log2 of samples per output.
REQ-007 SHALL have port s_axis_tdata  input  32  raw conversion word from the ADC manager.
REQ-008 SHALL have port s_axis_tvalid  input  1  raw word valid.
REQ-009 SHALL have port s_axis_tready  output  1  tied high whenever reset is deasserted; the block never back-pressures the ADC.
REQ-010 SHALL have port m_axis_tdata  output  32  averaged sample, sign-extended.
REQ-011 SHALL have port m_axis_tvalid  output  1  averaged sample valid.
REQ-012 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-013 SHALL have port status  output  32  [0] m_axis_tvalid, [1] state==ACCUM, [7:4] active ratio, [15:8] zero, [31:16] overrun count.

Function
REQ-014 SHALL implement states IDLE and ACCUM; IDLE->ACCUM when enable=1; any state->IDLE when enable=0, discarding the partial accumulator and count.
REQ-015 SHALL latch the active ratio from log2_ratio on IDLE->ACCUM and at every block boundary (count returns to 0), never mid-block; values above MAX_LOG2_RATIO clamp to MAX_LOG2_RATIO.
REQ-016 SHALL treat s_axis_tdata[31:8] as signed SAMPLE_WIDTH-bit sample; bits [7:0] ignored.
REQ-017 SHALL accept a sample on each cycle with s_axis_tvalid=1 in ACCUM; samples in IDLE are discarded.
REQ-018 SHALL accumulate in a signed register of SAMPLE_WIDTH+MAX_LOG2_RATIO bits, which cannot overflow.
REQ-019 SHALL count accepted samples 0 .. 2^ratio-1; on the last sample the result is (accumulator + sample) arithmetic-shifted right by ratio (floor), sign-extended to 32 bits.
REQ-020 SHALL restart the accumulator from zero (not from the last sum) after each block completes.
REQ-021 SHALL present the result on m_axis one cycle after the last sample is accepted; ratio 0 gives pass-through with 1-cycle latency.
REQ-022 SHALL hold m_axis_tdata/m_axis_tvalid stable until m_axis_tvalid && m_axis_tready; tvalid then drops next cycle unless a new result loads.
REQ-023 SHALL load a new result when the output register is empty or is being consumed in the same cycle; no overrun in that case.
REQ-024 SHALL, when a result completes while m_axis_tvalid=1 and m_axis_tready=0, drop the new result, keep the old one, and increment the overrun count.
REQ-025 SHALL saturate the overrun count at 16'hFFFF; it clears only on reset.
REQ-026 SHALL leave a pending output valid when enable falls; it drains normally.

Reset
REQ-027 SHALL on areset asynchronously clear state to IDLE, accumulator, sample count, active ratio, overrun count, m_axis_tdata and m_axis_tvalid to 0.
REQ-028 SHALL drive s_axis_tready 0 while areset is high and 1 otherwise.
REQ-029 SHALL resume only via IDLE->ACCUM with a fresh ratio latch after reset deasserts mid-block.

Structure
REQ-030 SHALL place the IDLE/ACCUM state encoding, the input sample bit offset (8), and the status field offsets in shared package adc_pkg, alongside the ADC manager's mode constants.
REQ-031 SHALL be a single module; the output register/overrun logic is inline. No sub-module is required.

Verification
REQ-032 SHALL verify: ratio=2, samples 100,200,300,400 (in [31:8]), tready=1 -> one output 250 one cycle after the 4th sample.
REQ-033 SHALL verify: ratio=1, samples -3,-4 -> output 0xFFFFFFFC (floor of -3.5); then samples 5,6 -> output 5.
REQ-034 SHALL verify: ratio=0, tready=0, three samples 1,2,3 -> m_axis holds 1, overrun count=2; tready=1 -> 1 consumed, tvalid drops.
REQ-035 SHALL verify: log2_ratio changes 2->3 after 2 samples of a block -> that block still ends after 4 samples; next block uses 8.
REQ-036 SHALL verify: log2_ratio=15 -> active ratio 8 in status[7:4], output after 256 samples equals the mean of a constant 0x7FFFFF input.
REQ-037 SHALL verify: areset pulsed after 3 of 4 samples -> all outputs 0; after release and enable, 4 new samples produce a correct average unaffected by the earlier partial sum.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants for the ADC front end: the ADC manager's mode encoding, the
// decimator state encoding, where the sample sits in the raw conversion word,
// and the decimator status word layout.
package adc_pkg;

  // ADC manager conversion modes.
  typedef enum logic [1:0] {
    ADC_MODE_OFF        = 2'd0,
    ADC_MODE_SINGLE     = 2'd1,
    ADC_MODE_CONTINUOUS = 2'd2,
    ADC_MODE_SCAN       = 2'd3
  } adc_mode_e;

  // Decimator states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } dec_state_e;

  // The signed sample occupies the raw word from this bit upward.
  localparam int unsigned SAMPLE_LSB = 8;

  // Status word field offsets.
  localparam int unsigned STAT_VALID_BIT = 0;
  localparam int unsigned STAT_ACCUM_BIT = 1;
  localparam int unsigned STAT_RATIO_LSB = 4;
  localparam int unsigned STAT_RATIO_W   = 4;
  localparam int unsigned STAT_OVR_LSB   = 16;
  localparam int unsigned STAT_OVR_W     = 16;

  // Requested ratios above the supported maximum use the maximum.
  function automatic logic [3:0] clamp_ratio(input logic [3:0] req,
                                             input int unsigned max_ratio);
    return (32'(req) > max_ratio) ? 4'(max_ratio) : req;
  endfunction

endpackage

// File: rtl/adc_decimator.sv
// Block-average decimator for ADC conversion words.
// Sums 2^ratio signed samples and emits the floor mean, sign-extended, on an
// AXI-stream style output register that never back-pressures the input; a
// result that completes while the output is stalled is dropped and counted.
//
// Ports:
//   aclk, areset          clock, async active-high reset
//   enable                run; low returns to IDLE and discards a partial block
//   log2_ratio[3:0]       requested log2 samples per output (clamped)
//   s_axis_tdata/tvalid   raw 32-bit word in, sample in [31:8]
//   s_axis_tready         high whenever reset is deasserted
//   m_axis_tdata/tvalid   averaged sample out; m_axis_tready from downstream
//   status[31:0]          [0] tvalid, [1] ACCUM, [7:4] ratio, [31:16] overruns
module adc_decimator
  import adc_pkg::*;
#(
  parameter int unsigned MAX_LOG2_RATIO = 8,
  parameter int unsigned SAMPLE_WIDTH   = 24
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [3:0]  log2_ratio,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] status
);

  localparam int unsigned ACC_W = SAMPLE_WIDTH + MAX_LOG2_RATIO;
  localparam int unsigned CNT_W = (MAX_LOG2_RATIO > 0) ? MAX_LOG2_RATIO : 1;
  localparam int unsigned OVR_W = STAT_OVR_W;

  dec_state_e               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               ratio_q, ratio_d;
  logic [31:0]              m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic [OVR_W-1:0]         ovr_q, ovr_d;

  logic signed [SAMPLE_WIDTH-1:0] sample_c;
  logic signed [ACC_W-1:0]        sum_c;
  logic signed [ACC_W-1:0]        mean_c;
  logic [CNT_W:0]                 blk_len_c;
  logic                           last_c;
  logic                           done_c;
  logic [3:0]                     ratio_req_c;
  logic                           unused_lsb_c;

  // Sample extraction; the low status bits of the raw word carry no data.
  assign sample_c     = s_axis_tdata[SAMPLE_LSB +: SAMPLE_WIDTH];
  assign unused_lsb_c = ^s_axis_tdata[SAMPLE_LSB-1:0];

  assign sum_c       = acc_q + ACC_W'(sample_c);
  assign mean_c      = sum_c >>> ratio_q;
  assign blk_len_c   = (CNT_W+1)'(1) << ratio_q;
  assign last_c      = ({1'b0, cnt_q} == (blk_len_c - (CNT_W+1)'(1)));
  assign done_c      = (state_q == ST_ACCUM) && enable && s_axis_tvalid && last_c;
  assign ratio_req_c = clamp_ratio(log2_ratio, MAX_LOG2_RATIO);

  // Next-state: block FSM, accumulator, and output register / overrun.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ratio_d   = ratio_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    ovr_d     = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ACCUM;
          ratio_d = ratio_req_c;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (s_axis_tvalid) begin
          if (last_c) begin
            // Block boundary: restart from zero and pick up a new ratio.
            acc_d   = '0;
            cnt_d   = '0;
            ratio_d = ratio_req_c;
          end else begin
            acc_d = sum_c;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
    if (done_c) begin
      if (!m_valid_q || m_axis_tready) begin
        m_data_d  = 32'(mean_c);
        m_valid_d = 1'b1;
      end else if (ovr_q != {OVR_W{1'b1}}) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ratio_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign s_axis_tready = ~areset;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;

  // Status word assembled directly from registers.
  always_comb begin
    status = '0;
    status[STAT_VALID_BIT]                     = m_valid_q;
    status[STAT_ACCUM_BIT]                     = (state_q == ST_ACCUM);
    status[STAT_RATIO_LSB +: STAT_RATIO_W]     = ratio_q;
    status[STAT_OVR_LSB +: STAT_OVR_W]         = ovr_q;
  end

endmodule

// File: tb/tb_adc_decimator.sv
// Directed bench for adc_decimator: expected averages go into a scoreboard
// queue as the last sample of each block is driven and are popped on every
// output handshake; point checks cover latency, status and reset behaviour.
module tb_adc_decimator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  log2_ratio = 4'd0;
  logic [31:0] s_axis_tdata = 32'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] status;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  adc_decimator #(.MAX_LOG2_RATIO(8), .SAMPLE_WIDTH(24)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .log2_ratio    (log2_ratio),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .status        (status)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic send(input int s);
    s_axis_tdata  = {24'(s), 8'($urandom)};
    s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
  endtask

  // Leave and re-enter ACCUM so a new ratio is latched.
  task automatic restart(input logic [3:0] r);
    enable = 1'b0;
    step();
    log2_ratio = r;
    enable = 1'b1;
    step();
  endtask

  // Floor of sum / 2^r, done as integer division with a negative correction.
  function automatic logic [31:0] floor_mean(input longint sum, input int r);
    longint d;
    longint q;
    d = longint'(1) << r;
    q = sum / d;
    if ((sum % d != 0) && (sum < 0)) q = q - 1;
    return 32'(q);
  endfunction

  // Scoreboard: every output handshake consumes one expected value.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL sb_unexpected: observed %h expected no output", m_axis_tdata);
      end
      if (exp_q.size() > 0) check("sb_data", m_axis_tdata, exp_q.pop_front());
    end
  end

  initial begin
    // Reset state.
    #1;
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    step();
    step();
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_status", status, 32'd0);
    areset = 1'b0;
    #1;
    check("run_s_tready", {31'd0, s_axis_tready}, 32'd1);

    // Ratio 2: 100,200,300,400 -> 250 one cycle after the fourth sample.
    restart(4'd2);
    check("r2_status", status, 32'h0000_0022);
    send(100);
    send(200);
    send(300);
    check("r2_no_early", {31'd0, m_axis_tvalid}, 32'd0);
    exp_q.push_back(32'd250);
    send(400);
    check("r2_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("r2_data", m_axis_tdata, 32'd250);
    step();
    check("r2_drop", {31'd0, m_axis_tvalid}, 32'd0);

    // Ratio 1: floor of -3.5, then a fresh block 5,6 -> 5.
    restart(4'd1);
    send(-3);
    exp_q.push_back(32'hFFFF_FFFC);
    send(-4);
    check("r1_neg", m_axis_tdata, 32'hFFFF_FFFC);
    send(5);
    exp_q.push_back(32'd5);
    send(6);
    check("r1_restart", m_axis_tdata, 32'd5);

    // Ratio change mid-block: the block still ends after 4, next uses 8.
    restart(4'd2);
    send(10);
    send(20);
    log2_ratio = 4'd3;
    send(30);
    exp_q.push_back(floor_mean(10 + 20 + 30 + 41, 2));
    send(41);
    check("chg_old_len", m_axis_tdata, 32'd25);
    check("chg_ratio", 32'(status[7:4]), 32'd3);
    for (int i = 1; i <= 4; i++) send(i * 7);
    check("chg_not_4", {31'd0, m_axis_tvalid}, 32'd0);
    for (int i = 5; i <= 7; i++) send(i * 7);
    exp_q.push_back(floor_mean(7 * 36, 3));
    send(8 * 7);
    check("chg_new_len", m_axis_tdata, 32'd31);

    // Ratio 0 with a stalled output: first result held, two overruns.
    restart(4'd0);
    m_axis_tready = 1'b0;
    exp_q.push_back(32'd1);
    send(1);
    send(2);
    send(3);
    check("ovr_hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("ovr_hold_data", m_axis_tdata, 32'd1);
    check("ovr_count", 32'(status[31:16]), 32'd2);
    m_axis_tready = 1'b1;
    step();
    check("ovr_drained", {31'd0, m_axis_tvalid}, 32'd0);

    // Oversized request clamps to 8; mean of a constant full-scale input.
    restart(4'd15);
    check("clamp_ratio", 32'(status[7:4]), 32'd8);
    for (int i = 0; i < 255; i++) send(32'h007F_FFFF);
    check("clamp_not_255", {31'd0, m_axis_tvalid}, 32'd0);
    exp_q.push_back(32'h007F_FFFF);
    send(32'h007F_FFFF);
    check("clamp_mean", m_axis_tdata, 32'h007F_FFFF);
    step();

    // Reset mid-block; the partial sum must not leak into the next block.
    restart(4'd2);
    send(1000);
    send(1000);
    send(1000);
    areset = 1'b1;
    #1;
    check("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("mid_rst_tdata", m_axis_tdata, 32'd0);
    check("mid_rst_status", status, 32'd0);
    check("mid_rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    step();
    areset = 1'b0;
    step();
    check("post_rst_status", status, 32'h0000_0022);
    send(-8);
    send(-8);
    send(-8);
    exp_q.push_back(floor_mean(-31, 2));
    send(-7);
    check("post_rst_data", m_axis_tdata, 32'hFFFF_FFF8);
    step();
    step();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
